muldiv_unit: RTL and testbench

Iterative multiply/divide unit in the execute stage, alongside the ALU. It takes the same a/b operand buses and implements MULT, MULTU, DIV, DIVU, MTHI and MTLO into architectural HI/LO registers. The hi/lo outputs feed the writeback mux for MFHI/MFLO. busy stalls the PC/fetch logic while an operation runs.

---
 rtl/muldiv_pkg.sv | 16 +
 rtl/muldiv_if.sv | 14 +
 rtl/muldiv_iter_core.sv | 45 ++++
 rtl/muldiv_unit.sv | 51 +++++
 tb/tb_muldiv_unit.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared op encodings, FSM state codes and width for the mul/div unit
package muldiv_pkg;
   localparam int XLEN = 32;
   localparam logic [2:0] OP_MULT  = 3'b000;
   localparam logic [2:0] OP_MULTU = 3'b001;
   localparam logic [2:0] OP_DIV   = 3'b010;
   localparam logic [2:0] OP_DIVU  = 3'b011;
   localparam logic [2:0] OP_MTHI  = 3'b100;
   localparam logic [2:0] OP_MTLO  = 3'b101;
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_FIX  = 2'd2;
   function automatic logic [XLEN-1:0] cneg(input logic [XLEN-1:0] v, input logic neg);
      return neg ? -v : v;
   endfunction
endpackage

// File: rtl/muldiv_if.sv
// muldiv_if: operand/request and HI/LO result bundle between execute control and the mul/div unit
interface muldiv_if;
   import muldiv_pkg::*;
   logic            start;
   logic [2:0]      op;
   logic [XLEN-1:0] a;
   logic [XLEN-1:0] b;
   logic            busy;
   logic            done;
   logic [XLEN-1:0] hi;
   logic [XLEN-1:0] lo;
   modport master(output start, op, a, b, input busy, done, hi, lo);
   modport slave(input start, op, a, b, output busy, done, hi, lo);
endinterface

// File: rtl/muldiv_iter_core.sv
// muldiv_iter_core: W-step radix-2 shift-add multiply / restoring divide on unsigned magnitudes
module muldiv_iter_core import muldiv_pkg::*; #(
   parameter int W = XLEN
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           load,
   input  logic           step,
   input  logic           div,
   input  logic [W-1:0]   ma,
   input  logic [W-1:0]   mb,
   output logic [2*W-1:0] acc,
   output logic           last_step
);
   localparam int CW = $clog2(W);
   logic [CW-1:0] cnt;
   logic [W-1:0]  m;
   logic [W:0]    sum;
   logic [W:0]    trial;
   logic [W-1:0]  diff;
   logic          ge;
   assign last_step = step && cnt == CW'(W-1);
   // one iteration: acc is {product_hi, multiplier} for multiply and {remainder, dividend/quotient} for divide
   always_comb begin
      sum   = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, m} : {(W+1){1'b0}});
      trial = {acc[2*W-1:W], acc[W-1]};
      ge    = trial >= {1'b0, m};
      diff  = trial[W-1:0] - m;
   end
   // accumulator, divisor/multiplicand and iteration counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc <= '0;
         m   <= '0;
         cnt <= '0;
      end else if (load) begin
         acc <= {{W{1'b0}}, ma};
         m   <= mb;
         cnt <= '0;
      end else if (step) begin
         acc <= div ? {ge ? diff : trial[W-1:0], acc[W-2:0], ge} : {sum, acc[W-1:1]};
         cnt <= cnt + 1'b1;
      end
   end
endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative MULT/MULTU/DIV/DIVU plus MTHI/MTLO into architectural HI/LO
module muldiv_unit import muldiv_pkg::*; (
   input logic     clk,
   input logic     rst_n,
   muldiv_if.slave bus
);
   logic [1:0]        state;
   logic              go, load, sa_in, sb_in, is_div, neg_a, neg_b, bz, last_step;
   logic [XLEN-1:0]   ma, mb, quo, rem;
   logic [2*XLEN-1:0] acc, prod;
   assign go        = bus.start && state == S_IDLE;
   assign load      = go && !bus.op[2];
   assign sa_in     = !bus.op[0] && bus.a[XLEN-1];
   assign sb_in     = !bus.op[0] && bus.b[XLEN-1];
   assign ma        = cneg(bus.a, sa_in);
   assign mb        = cneg(bus.b, sb_in);
   assign prod      = (neg_a ^ neg_b) ? -acc : acc;
   assign quo       = bz ? '1 : cneg(acc[XLEN-1:0], neg_a ^ neg_b);
   assign rem       = cneg(acc[2*XLEN-1:XLEN], neg_a);
   assign bus.busy  = state != S_IDLE;
   muldiv_iter_core #(.W(XLEN)) u_core (
      .clk(clk), .rst_n(rst_n), .load(load), .step(state == S_RUN), .div(is_div),
      .ma(ma), .mb(mb), .acc(acc), .last_step(last_step)
   );
   // IDLE -> RUN on an arithmetic start, RUN -> FIX after the last iteration, FIX -> IDLE
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else state <= state == S_IDLE ? (load ? S_RUN : S_IDLE) :
                    state == S_RUN  ? (last_step ? S_FIX : S_RUN) : S_IDLE;
   end
   // capture op kind, operand signs and the divide-by-zero flag when a request is accepted
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) {is_div, neg_a, neg_b, bz} <= '0;
      else if (load) {is_div, neg_a, neg_b, bz} <= {bus.op[1], sa_in, sb_in, bus.b == '0};
   end
   // HI/LO only change on the fix-up edge or an accepted MTHI/MTLO
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.hi   <= '0;
         bus.lo   <= '0;
         bus.done <= 1'b0;
      end else begin
         bus.done <= state == S_FIX;
         if (state == S_FIX) begin
            bus.hi <= is_div ? rem : prod[2*XLEN-1:XLEN];
            bus.lo <= is_div ? quo : prod[XLEN-1:0];
         end else if (go && bus.op == OP_MTHI) bus.hi <= bus.a;
         else if (go && bus.op == OP_MTLO) bus.lo <= bus.a;
      end
   end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed and randomized checks of muldiv_unit against an arithmetic reference model
module tb_muldiv_unit;
   import muldiv_pkg::*;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int total = 0;
   int bad = 0;
   muldiv_if bus();
   muldiv_unit dut(.clk(clk), .rst_n(rst_n), .bus(bus));
   always #5 clk = ~clk;

   function automatic void model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] h, output logic [31:0] l);
      longint sa, sb, r;
      logic [63:0] u;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      h = '0;
      l = '0;
      if (op == OP_MULT) begin
         r = sa * sb;
         u = r;
         {h, l} = u;
      end else if (op == OP_MULTU) begin
         u = {32'h0, a} * {32'h0, b};
         {h, l} = u;
      end else if (b == 32'h0) begin
         h = a;
         l = 32'hFFFF_FFFF;
      end else if (op == OP_DIV) begin
         r = sa / sb;
         l = 32'(r);
         r = sa % sb;
         h = 32'(r);
      end else begin
         l = a / b;
         h = a % b;
      end
   endfunction

   task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      bus.start = 1'b1;
      bus.op = op;
      bus.a = a;
      bus.b = b;
      @(negedge clk);
      bus.start = 1'b0;
      bus.op = 3'($urandom);
      bus.a = $urandom;
      bus.b = $urandom;
   endtask

   task automatic finish_op(input string nm, input int n0, input logic [31:0] eh, input logic [31:0] el);
      int n, bcnt;
      logic [31:0] oh, ol;
      logic held;
      n = n0;
      bcnt = n0;
      oh = bus.hi;
      ol = bus.lo;
      held = 1'b1;
      while (!bus.done && n < 40) begin
         if (bus.busy) bcnt++;
         if (bus.hi !== oh || bus.lo !== ol) held = 1'b0;
         @(negedge clk);
         n++;
      end
      total++;
      if (n !== 33 || bcnt !== 33) begin
         bad++;
         $display("FAIL %s timing: done at cycle %0d with %0d busy cycles, want 33 and 33", nm, n, bcnt);
      end
      total++;
      if (!held) begin
         bad++;
         $display("FAIL %s hold: hi/lo changed while busy (old hi=%h lo=%h)", nm, oh, ol);
      end
      total++;
      if (bus.hi !== eh || bus.lo !== el || bus.busy !== 1'b0) begin
         bad++;
         $display("FAIL %s result: got hi=%h lo=%h busy=%b, want hi=%h lo=%h busy=0", nm, bus.hi, bus.lo, bus.busy, eh, el);
      end
   endtask

   task automatic test_reset();
      bus.start = 1'b0;
      bus.op = '0;
      bus.a = '0;
      bus.b = '0;
      repeat (3) @(negedge clk);
      total++;
      if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.hi !== 32'h0 || bus.lo !== 32'h0) begin
         bad++;
         $display("FAIL reset: got busy=%b done=%b hi=%h lo=%h, want all zero", bus.busy, bus.done, bus.hi, bus.lo);
      end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_mul();
      issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      finish_op("multu_max", 0, 32'hFFFF_FFFE, 32'h0000_0001);
      @(negedge clk);
      total++;
      if (bus.done !== 1'b0) begin
         bad++;
         $display("FAIL done_width: done=%b one cycle after pulse, want 0", bus.done);
      end
      issue(OP_MULT, 32'hFFFF_FFFD, 32'h7);
      finish_op("mult_neg", 0, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
   endtask

   task automatic test_back_to_back();
      @(negedge clk);
      issue(OP_DIV, 32'hFFFF_FFF9, 32'h2);
      finish_op("div_neg", 0, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
      issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
      finish_op("div_ovf_b2b", 0, 32'h0, 32'h8000_0000);
   endtask

   task automatic test_div_zero();
      issue(OP_DIVU, 32'h1234_5678, 32'h0);
      finish_op("divu_zero", 0, 32'h1234_5678, 32'hFFFF_FFFF);
      issue(OP_DIV, 32'hFFFF_0000, 32'h0);
      finish_op("div_zero_neg", 0, 32'hFFFF_0000, 32'hFFFF_FFFF);
   endtask

   task automatic test_busy_ignore();
      issue(OP_DIVU, 32'd100, 32'd7);
      bus.start = 1'b1;
      bus.op = OP_MTHI;
      bus.a = 32'hAAAA_0000;
      @(negedge clk);
      bus.op = OP_DIV;
      bus.a = 32'd9;
      bus.b = 32'd3;
      @(negedge clk);
      bus.start = 1'b0;
      finish_op("busy_ignore", 2, 32'd2, 32'd14);
      @(negedge clk);
      issue(OP_MTLO, 32'd5, 32'd0);
      total++;
      if (bus.lo !== 32'd5 || bus.hi !== 32'd2 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
         bad++;
         $display("FAIL mtlo: got hi=%h lo=%h busy=%b done=%b, want hi=2 lo=5 busy=0 done=0", bus.hi, bus.lo, bus.busy, bus.done);
      end
      issue(OP_MTHI, 32'hDEAD_BEEF, 32'd0);
      total++;
      if (bus.hi !== 32'hDEAD_BEEF || bus.lo !== 32'd5 || bus.busy !== 1'b0) begin
         bad++;
         $display("FAIL mthi: got hi=%h lo=%h busy=%b, want hi=deadbeef lo=5 busy=0", bus.hi, bus.lo, bus.busy);
      end
      issue(3'b110, 32'h1111_1111, 32'h3);
      issue(3'b111, 32'h2222_2222, 32'h3);
      total++;
      if (bus.hi !== 32'hDEAD_BEEF || bus.lo !== 32'd5 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
         bad++;
         $display("FAIL reserved_op: got hi=%h lo=%h busy=%b done=%b, want hi=deadbeef lo=5 busy=0 done=0", bus.hi, bus.lo, bus.busy, bus.done);
      end
   endtask

   task automatic test_reset_abort();
      logic seen_done;
      issue(OP_MULT, 32'h0001_2345, 32'hFFFF_0789);
      repeat (9) @(negedge clk);
      rst_n = 1'b0;
      #1;
      total++;
      if (bus.hi !== 32'h0 || bus.lo !== 32'h0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
         bad++;
         $display("FAIL reset_abort: got hi=%h lo=%h busy=%b done=%b, want all zero", bus.hi, bus.lo, bus.busy, bus.done);
      end
      @(negedge clk);
      rst_n = 1'b1;
      seen_done = 1'b0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (bus.done || bus.busy) seen_done = 1'b1;
      end
      total++;
      if (seen_done) begin
         bad++;
         $display("FAIL reset_resume: busy or done seen after abort, want neither");
      end
      issue(OP_MULTU, 32'd6, 32'd7);
      finish_op("multu_after_reset", 0, 32'd0, 32'd42);
   endtask

   task automatic test_random();
      logic [2:0] op;
      logic [31:0] a, b, eh, el;
      for (int i = 0; i < 24; i++) begin
         op = 3'($urandom_range(0, 3));
         a = ($urandom_range(0, 5) == 0) ? 32'h8000_0000 : $urandom;
         case ($urandom_range(0, 5))
            0: b = 32'h0;
            1: b = 32'hFFFF_FFFF;
            2: b = 32'($urandom_range(1, 20));
            default: b = $urandom;
         endcase
         model(op, a, b, eh, el);
         issue(op, a, b);
         finish_op($sformatf("rand%0d_op%0d_%h_%h", i, op, a, b), 0, eh, el);
      end
   endtask

   initial begin
      test_reset();
      test_mul();
      test_back_to_back();
      test_div_zero();
      test_busy_ignore();
      test_reset_abort();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
